i2c_slave_regs: RTL and testbench

I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

---
 rtl/i2c_slave_regs.sv | 229 ++++++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regs.sv
// I2C slave that bridges bus transfers onto a 16-bit register address space.
// Read support is compiled in only when the I2C_SLAVE_READ_EN macro is defined.
module i2c_slave_regs_filt #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] LIM = CW'(FILT_LEN - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_q;

    // A new level is accepted only after FILT_LEN consecutive samples of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b11;
            r_cnt  <= '0;
            r_q    <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_d};
            if (r_sync[1] == r_q) begin
                r_cnt <= '0;
            end else if (r_cnt == LIM) begin
                r_q   <= r_sync[1];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_q = r_q;
endmodule

module i2c_slave_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h3C,
    parameter int         FILT_LEN = 3
) (
    input  logic        clock_sys,
    input  logic        rst,
    input  logic        i2c_sclk,
    inout  wire         i2c_sdat,
    output logic [15:0] reg_addr,
    output logic        reg_wr_en,
    output logic [7:0]  reg_wr_data,
    output logic        reg_rd_en,
    input  logic [7:0]  reg_rd_data,
    output logic        busy
);
    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, AHI, AHI_ACK, ALO, ALO_ACK,
        WDAT, WDAT_ACK, RDAT, RDAT_ACK, IGNORE
    } state_t;

`ifdef I2C_SLAVE_READ_EN
    localparam logic READ_EN = 1'b1;
    logic r_rd_en, r_rd_lat, r_rw, r_mack;
`else
    localparam logic READ_EN = 1'b0;
`endif

    state_t      r_state, w_nxt;
    logic        w_scl_f, w_sda_f, r_scl_d, r_sda_d;
    logic        w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]  r_shift, w_byte;
    logic [2:0]  r_bitcnt;
    logic        w_last, w_ack_dev, w_unused;
    logic        r_sda_oe, r_wr_en, r_busy;
    logic [15:0] r_addr;
    logic [7:0]  r_wr_data;

    i2c_slave_regs_filt #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk(clock_sys), .rst(rst), .i_d(i2c_sclk), .o_q(w_scl_f));
    i2c_slave_regs_filt #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk(clock_sys), .rst(rst), .i_d(i2c_sdat), .o_q(w_sda_f));

    assign w_scl_rise = w_scl_f & ~r_scl_d;
    assign w_scl_fall = ~w_scl_f & r_scl_d;
    assign w_start    = w_scl_f & r_scl_d & r_sda_d & ~w_sda_f;
    assign w_stop     = w_scl_f & r_scl_d & ~r_sda_d & w_sda_f;
    assign w_byte     = {r_shift[6:0], w_sda_f};
    assign w_last     = (r_bitcnt == 3'd7);
    assign w_ack_dev  = (w_byte[7:1] == DEV_ADDR) && (READ_EN || !w_byte[0]);

    always_ff @(posedge clock_sys) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nxt;
    end

    // In ACK states the first SCL fall starts the ACK and the second one ends it.
    always_comb begin
        w_nxt = r_state;
        if (w_stop) begin
            w_nxt = IDLE;
        end else if (w_start) begin
            w_nxt = DEV;
        end else begin
            case (r_state)
                DEV:      if (w_scl_rise && w_last) w_nxt = w_ack_dev ? DEV_ACK : IGNORE;
`ifdef I2C_SLAVE_READ_EN
                DEV_ACK:  if (w_scl_fall && r_sda_oe) w_nxt = r_rw ? RDAT : AHI;
                RDAT:     if (w_scl_fall && r_bitcnt == 3'd0) w_nxt = RDAT_ACK;
                RDAT_ACK: if (w_scl_fall) w_nxt = r_mack ? RDAT : IGNORE;
`else
                DEV_ACK:  if (w_scl_fall && r_sda_oe) w_nxt = AHI;
`endif
                AHI:      if (w_scl_rise && w_last) w_nxt = AHI_ACK;
                AHI_ACK:  if (w_scl_fall && r_sda_oe) w_nxt = ALO;
                ALO:      if (w_scl_rise && w_last) w_nxt = ALO_ACK;
                ALO_ACK:  if (w_scl_fall && r_sda_oe) w_nxt = WDAT;
                WDAT:     if (w_scl_rise && w_last) w_nxt = WDAT_ACK;
                WDAT_ACK: if (w_scl_fall && r_sda_oe) w_nxt = WDAT;
                default:  w_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clock_sys) begin
        if (rst) begin
            r_scl_d   <= 1'b1;
            r_sda_d   <= 1'b1;
            r_sda_oe  <= 1'b0;
            r_addr    <= 16'h0000;
            r_wr_en   <= 1'b0;
            r_wr_data <= 8'h00;
            r_busy    <= 1'b0;
            r_shift   <= 8'h00;
            r_bitcnt  <= 3'd0;
`ifdef I2C_SLAVE_READ_EN
            r_rd_en   <= 1'b0;
            r_rd_lat  <= 1'b0;
            r_rw      <= 1'b0;
            r_mack    <= 1'b0;
`endif
        end else begin
            r_scl_d <= w_scl_f;
            r_sda_d <= w_sda_f;
            r_wr_en <= 1'b0;
            if (r_wr_en) r_addr <= r_addr + 16'd1;
`ifdef I2C_SLAVE_READ_EN
            r_rd_en  <= 1'b0;
            r_rd_lat <= r_rd_en;
`endif
            if (w_stop) begin
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_start) begin
                r_sda_oe <= 1'b0;
                r_bitcnt <= 3'd0;
            end else begin
                case (r_state)
                    DEV, AHI, ALO, WDAT: if (w_scl_rise) begin
                        r_shift  <= w_byte;
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (w_last) begin
                            case (r_state)
                                DEV: begin
                                    if (w_ack_dev) r_busy <= 1'b1;
`ifdef I2C_SLAVE_READ_EN
                                    r_rw <= w_byte[0];
`endif
                                end
                                AHI:     r_addr[15:8] <= w_byte;
                                ALO:     r_addr[7:0]  <= w_byte;
                                default: begin
                                    r_wr_en   <= 1'b1;
                                    r_wr_data <= w_byte;
                                end
                            endcase
                        end
                    end
                    DEV_ACK, AHI_ACK, ALO_ACK, WDAT_ACK: if (w_scl_fall) begin
                        r_sda_oe <= ~r_sda_oe;
                        r_bitcnt <= 3'd0;
`ifdef I2C_SLAVE_READ_EN
                        if (r_state == DEV_ACK && r_sda_oe && r_rw) r_rd_en <= 1'b1;
`endif
                    end
`ifdef I2C_SLAVE_READ_EN
                    RDAT: begin
                        if (w_scl_rise) r_bitcnt <= r_bitcnt + 3'd1;
                        if (w_scl_fall) begin
                            if (r_bitcnt == 3'd0) begin
                                r_sda_oe <= 1'b0;
                            end else begin
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_sda_oe <= ~r_shift[6];
                            end
                        end
                        // Fetched byte arrives while SCL is still low; put bit 7 out at once.
                        if (r_rd_lat) begin
                            r_shift  <= reg_rd_data;
                            r_sda_oe <= ~reg_rd_data[7];
                        end
                    end
                    RDAT_ACK: begin
                        if (w_scl_rise) r_mack <= ~w_sda_f;
                        if (w_scl_fall && r_mack) begin
                            r_addr   <= r_addr + 16'd1;
                            r_rd_en  <= 1'b1;
                            r_bitcnt <= 3'd0;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

`ifdef I2C_SLAVE_READ_EN
    assign reg_rd_en = r_rd_en;
    assign w_unused  = r_shift[7];
`else
    assign reg_rd_en = 1'b0;
    assign w_unused  = ^{reg_rd_data, r_shift[7]};
`endif

    assign i2c_sdat    = r_sda_oe ? 1'b0 : 1'bz;
    assign reg_addr    = r_addr;
    assign reg_wr_en   = r_wr_en;
    assign reg_wr_data = r_wr_data;
    assign busy        = r_busy;
endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed plus randomized bus transfers against an address/data model of the
// register bridge; read tests are built when I2C_SLAVE_READ_EN is defined.
module tb_i2c_slave_regs;
    localparam int Q = 12;

    logic        clk = 1'b0, rst = 1'b1, m_scl = 1'b1, m_sda_lo = 1'b0;
    logic [7:0]  rd_data = 8'h00;
    logic [15:0] reg_addr;
    logic        reg_wr_en, reg_rd_en, busy;
    logic [7:0]  reg_wr_data;
    wire         sda;

    assign sda = m_sda_lo ? 1'b0 : 1'bz;
    pullup (sda);
    always #5 clk = ~clk;

    i2c_slave_regs dut (
        .clock_sys(clk), .rst(rst), .i2c_sclk(m_scl), .i2c_sdat(sda),
        .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
        .reg_rd_en(reg_rd_en), .reg_rd_data(rd_data), .busy(busy));

    int          n_chk = 0, n_fail = 0;
    int          n_dut_low = 0, n_wr_dbl = 0, n_inc_err = 0;
    logic [23:0] wq[$];
    logic [15:0] rq[$];
    logic [7:0]  mem [0:65535];
    logic        p_wr = 1'b0;
    logic [15:0] p_addr = 16'h0000;

    // Register-side environment: records strobes and serves read data.
    always @(negedge clk) begin
        if (reg_wr_en) wq.push_back({reg_addr, reg_wr_data});
        if (p_wr && reg_wr_en) n_wr_dbl++;
        if (p_wr && reg_addr !== p_addr + 16'd1) n_inc_err++;
        if (reg_rd_en) begin
            rq.push_back(reg_addr);
            rd_data = mem[reg_addr];
        end
        if (sda === 1'b0 && !m_sda_lo) n_dut_low++;
        p_wr   = reg_wr_en;
        p_addr = reg_addr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(input logic b, input logic glitch);
        m_sda_lo = !b;
        tick(Q/2);
        if (glitch) begin
            m_scl = 1'b1; tick(1); m_scl = 1'b0; tick(Q/2 - 1);
        end else tick(Q/2);
        m_scl = 1'b1; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic bit_in(output logic b);
        m_sda_lo = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q/2);
        b = sda; tick(Q/2);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, input int gl_bit, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) bit_out(d[i], i == gl_bit);
        bit_in(a);
        ack = !a;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            d[i] = b;
        end
        bit_out(!mack, 1'b0);
    endtask

    task automatic start_c();
        if (!m_scl) begin
            m_sda_lo = 1'b0; tick(Q); m_scl = 1'b1; tick(Q);
        end
        m_sda_lo = 1'b1; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic stop_c();
        m_sda_lo = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda_lo = 1'b0; tick(2*Q);
    endtask

    // Model: a matching write address is ACKed throughout, data byte k lands at
    // (a + k) mod 2^16 and the pointer ends at a + n; otherwise nothing happens.
    task automatic do_write(input logic [7:0] dev, input logic [15:0] a, input int n,
                            input logic [3:0][7:0] dat, input int gl);
        logic ack, exp_ack;
        logic [15:0] a0;
        int low0;
        exp_ack = (dev == 8'h78);
        a0 = reg_addr;
        low0 = n_dut_low;
        wq.delete();
        start_c();
        send_byte(dev, -1, ack);
        chk("dev_ack", {31'd0, ack}, {31'd0, exp_ack});
        chk("busy_on", {31'd0, busy}, {31'd0, exp_ack});
        send_byte(a[15:8], -1, ack);
        chk("ahi_ack", {31'd0, ack}, {31'd0, exp_ack});
        send_byte(a[7:0], -1, ack);
        chk("alo_ack", {31'd0, ack}, {31'd0, exp_ack});
        for (int k = 0; k < n; k++) begin
            send_byte(dat[k], (k == 0) ? gl : -1, ack);
            chk("wdat_ack", {31'd0, ack}, {31'd0, exp_ack});
        end
        stop_c();
        chk("busy_off", {31'd0, busy}, 32'd0);
        chk("wr_count", wq.size(), exp_ack ? n : 0);
        for (int k = 0; k < wq.size() && k < n; k++)
            chk("wr_entry", {8'd0, wq[k]}, {8'd0, 16'(a + 16'(k)), dat[k]});
        chk("end_addr", {16'd0, reg_addr}, {16'd0, exp_ack ? 16'(a + 16'(n)) : a0});
        if (!exp_ack) chk("no_sda_low", n_dut_low - low0, 0);
    endtask

`ifdef I2C_SLAVE_READ_EN
    task automatic do_read(input logic [15:0] a, input int n, input logic [3:0][7:0] dat);
        logic ack, b;
        logic [7:0] d;
        for (int k = 0; k < n; k++) mem[16'(a + 16'(k))] = dat[k];
        rq.delete();
        start_c();
        send_byte(8'h78, -1, ack);   chk("rd_dev_ack", {31'd0, ack}, 32'd1);
        send_byte(a[15:8], -1, ack); chk("rd_ahi_ack", {31'd0, ack}, 32'd1);
        send_byte(a[7:0], -1, ack);  chk("rd_alo_ack", {31'd0, ack}, 32'd1);
        start_c();
        send_byte(8'h79, -1, ack);   chk("rd_79_ack", {31'd0, ack}, 32'd1);
        for (int k = 0; k < n; k++) begin
            recv_byte(k < n - 1, d);
            chk("rd_byte", {24'd0, d}, {24'd0, dat[k]});
        end
        bit_in(b);
        chk("ignore_released", {31'd0, b}, 32'd1);
        stop_c();
        chk("rd_count", rq.size(), n);
        for (int k = 0; k < rq.size() && k < n; k++)
            chk("rd_addr", {16'd0, rq[k]}, {16'd0, 16'(a + 16'(k))});
        chk("busy_off_rd", {31'd0, busy}, 32'd0);
    endtask
`endif

    initial begin
        logic ack;
        logic [7:0] dev;
        logic [3:0][7:0] dat;
        int low0;

        tick(5);
        rst = 1'b0;
        tick(5);
        chk("rst_addr", {16'd0, reg_addr}, 32'd0);
        chk("rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
        chk("rst_wr_data", {24'd0, reg_wr_data}, 32'd0);
        chk("rst_rd_en", {31'd0, reg_rd_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sda", {31'd0, sda}, 32'd1);

        dat = 32'h0000_0082; do_write(8'h78, 16'h3008, 1, dat, -1);
        dat = 32'h0000_2211; do_write(8'h78, 16'hFFFF, 2, dat, -1);
        dat = 32'h0000_0000; do_write(8'h42, 16'h0000, 0, dat, -1);
        dat = 32'h0000_00A5; do_write(8'h78, 16'h1234, 1, dat, 3);

        // Abort after four data bits.
        wq.delete();
        start_c();
        send_byte(8'h78, -1, ack);
        send_byte(8'h56, -1, ack);
        send_byte(8'h78, -1, ack);
        for (int i = 7; i >= 4; i--) bit_out(1'b1, 1'b0);
        stop_c();
        chk("abort_no_wr", wq.size(), 0);
        chk("abort_addr", {16'd0, reg_addr}, 32'h5678);
        chk("abort_busy", {31'd0, busy}, 32'd0);

        // Reset while the device-address ACK is being driven.
        start_c();
        for (int i = 7; i >= 0; i--) bit_out(8'h78 >> i, 1'b0);
        m_sda_lo = 1'b0;
        tick(Q);
        chk("ack_driven", {31'd0, sda}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_release", {31'd0, sda}, 32'd1);
        tick(1);
        rst = 1'b0;
        m_scl = 1'b1; tick(Q);
        m_scl = 1'b0; tick(Q);
        stop_c();
        chk("rst_mid_addr", {16'd0, reg_addr}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);

`ifdef I2C_SLAVE_READ_EN
        dat = 32'h0000_4056; do_read(16'h300A, 2, dat);
        for (int it = 0; it < 3; it++) begin
            dat = $urandom;
            do_read(16'($urandom), $urandom_range(1, 4), dat);
        end
`else
        rq.delete();
        low0 = n_dut_low;
        start_c();
        send_byte(8'h79, -1, ack);
        chk("noread_nack", {31'd0, ack}, 32'd0);
        chk("noread_rd_en", {31'd0, reg_rd_en}, 32'd0);
        stop_c();
        chk("noread_no_rd", rq.size(), 0);
        chk("noread_no_low", n_dut_low - low0, 0);
`endif

        for (int it = 0; it < 6; it++) begin
            dev = 8'h78;
            if ($urandom_range(0, 3) == 0) begin
                dev = {7'($urandom), 1'b0};
                if (dev == 8'h78) dev = 8'h7A;
            end
            dat = $urandom;
            do_write(dev, 16'($urandom), $urandom_range(1, 3), dat,
                     ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : -1);
        end

        chk("wr_single_cycle", n_wr_dbl, 0);
        chk("addr_inc_after_wr", n_inc_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
